noc_port_arbiter: RTL

Round-robin arbiter that shares one NoC router injection port between NUM_REQ traffic sources (traffic generators or user cores), each with a valid/ready flit interface. It holds the winning flit in a one-entry output register toward the router port. It also keeps a per-requester accepted-flit count for the traffic analysis flow. Flits pass through unmodified; packet fields (return, src, dst, VC, ID, data) are owned by the sources.

---
 rtl/noc_pkg.sv | 47 ++++
 rtl/noc_port_arbiter_rr_pick.sv | 28 ++
 rtl/noc_port_arbiter.sv | 81 ++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field positions used by traffic generators/sinks,
// the output buffer state type and the round-robin wrap helper.
package noc_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

  localparam int ID_WIDTH = 8;

  // Header packs MSB-first: return, return VC, src, dst, VC, ID; data fills the rest down to bit 0.
  function automatic int field_lsb(input int width, input int n, input int num_vc, input int field);
    int fw[6];
    int pos;
    fw  = '{1, $clog2((num_vc > 1) ? num_vc : 2), $clog2((n > 1) ? n : 2),
            $clog2((n > 1) ? n : 2), $clog2((num_vc > 1) ? num_vc : 2), ID_WIDTH};
    pos = width;
    for (int k = 0; k < 6; k++)
      if (k <= field) pos -= fw[k];
    return (field >= 6) ? 0 : pos;
  endfunction

  function automatic int RETURN_POS(input int width, input int n, input int num_vc);
    return field_lsb(width, n, num_vc, 0);
  endfunction
  function automatic int RETURNVC_POS(input int width, input int n, input int num_vc);
    return field_lsb(width, n, num_vc, 1);
  endfunction
  function automatic int SRC_POS(input int width, input int n, input int num_vc);
    return field_lsb(width, n, num_vc, 2);
  endfunction
  function automatic int DST_POS(input int width, input int n, input int num_vc);
    return field_lsb(width, n, num_vc, 3);
  endfunction
  function automatic int VC_POS(input int width, input int n, input int num_vc);
    return field_lsb(width, n, num_vc, 4);
  endfunction
  function automatic int ID_POS(input int width, input int n, input int num_vc);
    return field_lsb(width, n, num_vc, 5);
  endfunction
  function automatic int DATA_POS(input int width, input int n, input int num_vc);
    return field_lsb(width, n, num_vc, 6);
  endfunction

  function automatic int next_idx(input int i, input int num_req);
    return (i >= num_req - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/noc_port_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping at NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ        = 4,
  parameter int REQ_ADDR_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [REQ_ADDR_WIDTH-1:0] ptr,
  output logic                      any,
  output logic [REQ_ADDR_WIDTH-1:0] idx
);

  int pos;

  // Walk the search order backwards so the closest-to-ptr valid index is written last.
  always_comb begin
    idx = '0;
    pos = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++)
        if (req[j] && pos == j) idx = REQ_ADDR_WIDTH'(j);
    end
  end

  assign any = |req;

endmodule

// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter sharing one NoC injection port among NUM_REQ sources, with a
// one-entry output register and saturating per-requester accepted-flit counters.
module noc_port_arbiter
  import noc_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int NUM_REQ        = 4,
  parameter int REQ_ADDR_WIDTH = $clog2(NUM_REQ),
  parameter int CNT_WIDTH      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*WIDTH-1:0]       req_data_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  output logic [WIDTH-1:0]               data_out,
  output logic                           valid_out,
  input  logic                           ready_in,
  output logic [REQ_ADDR_WIDTH-1:0]      grant_id_out,
  output logic [NUM_REQ*CNT_WIDTH-1:0]   flit_count_out
);

  buf_state_t                          state, state_next;
  logic [REQ_ADDR_WIDTH-1:0]           ptr, win;
  logic                                any, can_accept, accept;
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0]   cnt;
  logic [NUM_REQ-1:0][WIDTH-1:0]       req_flits;

  assign req_flits = req_data_in;

  rr_pick #(.NUM_REQ(NUM_REQ), .REQ_ADDR_WIDTH(REQ_ADDR_WIDTH)) u_pick (
    .req (req_valid_in),
    .ptr (ptr),
    .any (any),
    .idx (win)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept)                         state_next = FULL;
    else if (state == FULL && ready_in) state_next = EMPTY;
  end

  // Ready is gated by rst so nothing handshakes while the buffer is being cleared.
  always_comb begin
    valid_out     = (state == FULL);
    can_accept    = (state == EMPTY) || ready_in;
    accept        = can_accept && any && !rst;
    req_ready_out = '0;
    if (accept) req_ready_out[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out     <= '0;
      grant_id_out <= '0;
      ptr          <= '0;
    end else if (accept) begin
      data_out     <= req_flits[win];
      grant_id_out <= win;
      ptr          <= REQ_ADDR_WIDTH'(next_idx(int'(win), NUM_REQ));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst)
        cnt[i] <= '0;
      else if (accept && win == REQ_ADDR_WIDTH'(i) && cnt[i] != '1)
        cnt[i] <= cnt[i] + 1'b1;
    end
  end

  assign flit_count_out = cnt;

endmodule
